// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode encodings, instruction classes, the XLEN-free part
// of the decoded bundle, and index/opcode helpers.
package decode_pkg;

    localparam logic [6:0] OP_R = 7'b0000001;
    localparam logic [6:0] OP_I = 7'b0000011;
    localparam logic [6:0] OP_U = 7'b0000111;
    localparam logic [6:0] OP_B = 7'b0001111;

    typedef enum logic [2:0] {
        IT_R,
        IT_I,
        IT_U,
        IT_B,
        IT_ILLEGAL
    } itype_e;

    // Width-independent control fields; the stage wraps these with its XLEN-wide data.
    typedef struct packed {
        logic [6:0] opcode;
        logic [3:0] aluop;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       hata;
    } decode_ctrl_t;

    function automatic itype_e classify(input logic [6:0] op);
        case (op)
            OP_R:    return IT_R;
            OP_I:    return IT_I;
            OP_U:    return IT_U;
            OP_B:    return IT_B;
            default: return IT_ILLEGAL;
        endcase
    endfunction

    function automatic logic idx_ok(input logic [4:0] idx, input int nregs);
        return int'(idx) < nregs;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for decode_stage: NREGS x XLEN, two combinational read ports, one write port.
// Index 0 and indices >= NREGS read as zero and ignore writes.
module decode_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      i_ra1,
    input  logic [4:0]      i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    input  logic            i_we,
    input  logic [4:0]      i_wa,
    input  logic [XLEN-1:0] i_wd
);

    // Register 0 is hardwired, so storage starts at index 1.
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_we && i_wa == 5'(i)) begin
                    r_regs[i] <= i_wd;
                end
            end
        end
    end

    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (i_ra1 == 5'(i)) o_rd1 = r_regs[i];
            if (i_ra2 == 5'(i)) o_rd2 = r_regs[i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: valid/ready instruction decoder with register file and one registered output slot.
// Optional macro DECODE_WB_BYPASS_EN forwards same-edge write-back data into captured operands.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          komut,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           opcode,
    output logic [3:0]           aluop,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic [XLEN-1:0]      imm,
    output logic                 hata,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef struct packed {
        decode_ctrl_t    ctrl;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } bundle_t;

    decode_ctrl_t          w_ctrl;
    logic [XLEN-1:0]       w_imm;
    logic [XLEN-1:0]       w_rf_rd1;
    logic [XLEN-1:0]       w_rf_rd2;
    logic [XLEN-1:0]       w_op1;
    logic [XLEN-1:0]       w_op2;
    logic                  w_ok1;
    logic                  w_ok2;
    logic                  w_okd;
    logic                  w_accept;
    bundle_t               w_next;
    bundle_t               r_bundle;
    logic                  r_out_valid;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    // Field extraction; unused index fields stay 0 so they never trip the range check.
    always_comb begin
        w_ctrl        = '0;
        w_imm         = '0;
        w_ctrl.opcode = komut[6:0];
        case (classify(komut[6:0]))
            IT_R: begin
                w_ctrl.rs1   = komut[19:15];
                w_ctrl.rs2   = komut[24:20];
                w_ctrl.rd    = komut[11:7];
                w_ctrl.aluop = {komut[30], komut[14:12]};
            end
            IT_I: begin
                w_ctrl.rs1   = komut[19:15];
                w_ctrl.rd    = komut[11:7];
                w_ctrl.aluop = {1'b0, komut[14:12]};
                w_imm        = {{(XLEN-12){1'b0}}, komut[31:20]};
            end
            IT_U: begin
                w_ctrl.rd    = komut[11:7];
                w_imm        = {{(XLEN-20){1'b0}}, komut[31:12]};
            end
            IT_B: begin
                w_ctrl.rs1   = komut[19:15];
                w_ctrl.rs2   = komut[24:20];
                w_ctrl.aluop = {1'b0, komut[14:12]};
                w_imm        = {{(XLEN-13){1'b0}}, komut[31:25], komut[11:7], 1'b0};
            end
            default: begin
                w_ctrl.hata  = 1'b1;
            end
        endcase
    end

    decode_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_ctrl.rs1),
        .i_ra2 (w_ctrl.rs2),
        .o_rd1 (w_rf_rd1),
        .o_rd2 (w_rf_rd2),
        .i_we  (wb_en),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

`ifdef DECODE_WB_BYPASS_EN
    // Out-of-range indices are zeroed below, so only the nonzero test is needed here.
    assign w_op1 = (wb_en && wb_addr == w_ctrl.rs1 && w_ctrl.rs1 != 5'd0) ? wb_data : w_rf_rd1;
    assign w_op2 = (wb_en && wb_addr == w_ctrl.rs2 && w_ctrl.rs2 != 5'd0) ? wb_data : w_rf_rd2;
`else
    assign w_op1 = w_rf_rd1;
    assign w_op2 = w_rf_rd2;
`endif

    assign w_ok1 = idx_ok(w_ctrl.rs1, NREGS);
    assign w_ok2 = idx_ok(w_ctrl.rs2, NREGS);
    assign w_okd = idx_ok(w_ctrl.rd, NREGS);

    always_comb begin
        w_next           = '0;
        w_next.ctrl      = w_ctrl;
        w_next.ctrl.hata = w_ctrl.hata | ~(w_ok1 & w_ok2 & w_okd);
        w_next.rs1_data  = w_ok1 ? w_op1 : '0;
        w_next.rs2_data  = w_ok2 ? w_op2 : '0;
        w_next.imm       = w_imm;
    end

    // Handshake: a stalled slot (out_valid && !out_ready) blocks the input with no skid buffer.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_bundle    <= w_next;
                r_out_valid <= 1'b1;
                if (w_next.ctrl.hata && r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign opcode    = r_bundle.ctrl.opcode;
    assign aluop     = r_bundle.ctrl.aluop;
    assign rs1       = r_bundle.ctrl.rs1;
    assign rs2       = r_bundle.ctrl.rs2;
    assign rd        = r_bundle.ctrl.rd;
    assign hata      = r_bundle.ctrl.hata;
    assign rs1_data  = r_bundle.rs1_data;
    assign rs2_data  = r_bundle.rs2_data;
    assign imm       = r_bundle.imm;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (NREGS=16): directed vector table, stall/reset sequences,
// and randomized traffic against a behavioural model. Honours DECODE_WB_BYPASS_EN.
module tb_decode_stage;

    localparam int XLEN      = 32;
    localparam int NREGS     = 16;
    localparam int ERR_CNT_W = 8;
    localparam int BW        = 7 + 4 + 15 + 1 + 3 * XLEN;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          komut;
    logic                 out_valid;
    logic                 out_ready;
    logic [6:0]           opcode;
    logic [3:0]           aluop;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [XLEN-1:0]      imm;
    logic                 hata;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic [ERR_CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    decode_stage #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .komut     (komut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .aluop     (aluop),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .hata      (hata),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .err_count (err_count)
    );

    logic [BW-1:0] dut_bundle;
    assign dut_bundle = {opcode, aluop, rs1, rs2, rd, hata, rs1_data, rs2_data, imm};

    int            n_checks = 0;
    int            n_errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [31:0]   m_regs[32];
    logic          m_valid;
    logic [BW-1:0] m_slot;
    int            m_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input int idx, input logic we, input int wa,
                                           input logic [31:0] wd);
        if (idx == 0 || idx >= NREGS) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == idx) return wd;
`endif
        return m_regs[idx];
    endfunction

    // Reference decode from the instruction-format rules, using shifts and masks.
    function automatic logic [BW-1:0] m_decode(input logic [31:0] k, input logic we, input int wa,
                                               input logic [31:0] wd);
        int op, f3, a, r1, r2, rdx;
        logic bad;
        logic [31:0] im, d1, d2;
        op = int'(k & 32'h7f);
        f3 = int'((k >> 12) & 32'h7);
        a = 0; r1 = 0; r2 = 0; rdx = 0; im = 0; bad = 1'b0;
        case (op)
            1: begin
                r1 = int'((k >> 15) & 31); r2 = int'((k >> 20) & 31); rdx = int'((k >> 7) & 31);
                a = f3 + int'((k >> 30) & 1) * 8;
            end
            3: begin
                r1 = int'((k >> 15) & 31); rdx = int'((k >> 7) & 31); a = f3; im = k >> 20;
            end
            7: begin
                rdx = int'((k >> 7) & 31); im = k >> 12;
            end
            15: begin
                r1 = int'((k >> 15) & 31); r2 = int'((k >> 20) & 31); a = f3;
                im = ((k >> 25) << 6) | (((k >> 7) & 32'd31) << 1);
            end
            default: bad = 1'b1;
        endcase
        if (r1 >= NREGS || r2 >= NREGS || rdx >= NREGS) bad = 1'b1;
        d1 = m_read(r1, we, wa, wd);
        d2 = m_read(r2, we, wa, wd);
        return {7'(op), 4'(a), 5'(r1), 5'(r2), 5'(rdx), bad, d1, d2, im};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0;
        m_slot  = '0;
        m_err   = 0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, check handshake, update model, check slot at next negedge.
    task automatic step(input logic v, input logic [31:0] k, input logic ordy,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [BW-1:0] b;
        logic          acc;
        in_valid = v; komut = k; out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        chk("in_ready", in_ready, !m_valid || ordy);
        acc = v && (!m_valid || ordy);
        if (m_valid && ordy) begin
            if (exp_q.size() == 0) chk("consume_empty", 1'b1, 1'b0);
            else chk("consume", dut_bundle, exp_q.pop_front());
        end
        if (acc) begin
            b = m_decode(k, we, int'(wa), wd);
            exp_q.push_back(b);
            m_slot  = b;
            m_valid = 1'b1;
            if (b[3*XLEN] && m_err < (1 << ERR_CNT_W) - 1) m_err++;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (we && wa != 5'd0 && int'(wa) < NREGS) m_regs[wa] = wd;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("err_count", err_count, m_err);
        chk("bundle", dut_bundle, m_slot);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; komut = '0; out_ready = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bundle", dut_bundle, 0);
        chk("rst_in_ready", in_ready, 1'b1);
    endtask

    typedef struct {
        logic [31:0] k;
        logic [3:0]  aluop;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        hata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [BW-1:0] held;
        logic [31:0]   k;
        logic [4:0]    wa;
        logic [6:0]    ops[5];

        vecs[0] = '{32'h4002_D181, 4'b1101, 32'h0,         32'hAA, 32'h0,  1'b0}; // R x5,x0 -> x3
        vecs[1] = '{32'hFFF2_A083, 4'b0010, 32'h0000_0FFF, 32'hAA, 32'h0,  1'b0}; // I imm=FFF
        vecs[2] = '{32'hABCD_E107, 4'b0000, 32'h000A_BCDE, 32'h0,  32'h0,  1'b0}; // U
        vecs[3] = '{32'hFE02_8F8F, 4'b0000, 32'h0000_1FFE, 32'hAA, 32'h0,  1'b0}; // B max imm
        vecs[4] = '{32'hFFFF_FFFF, 4'b0000, 32'h0,         32'h0,  32'h0,  1'b1}; // illegal opcode
        vecs[5] = '{32'h0142_8181, 4'b0000, 32'h0,         32'hAA, 32'h0,  1'b1}; // rs2=20 >= NREGS
        vecs[6] = '{32'h0052_8A01, 4'b0000, 32'h0,         32'hAA, 32'hAA, 1'b1}; // rd=20 >= NREGS

        do_reset();

        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h0000_00AA);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, vecs[i].k, 1'b1, 1'b0, 5'd0, 32'h0);
            chk($sformatf("vec%0d_aluop", i), aluop, vecs[i].aluop);
            chk($sformatf("vec%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("vec%0d_rs1_data", i), rs1_data, vecs[i].d1);
            chk($sformatf("vec%0d_rs2_data", i), rs2_data, vecs[i].d2);
            chk($sformatf("vec%0d_hata", i), hata, vecs[i].hata);
        end
        chk("vec_err_count", err_count, 3);

        // Stall for three cycles with a new instruction waiting, then release.
        step(1'b1, vecs[0].k, 1'b1, 1'b0, 5'd0, 32'h0);
        held = dut_bundle;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, vecs[2].k, 1'b0, 1'b0, 5'd0, 32'h0);
            chk("stall_hold", dut_bundle, held);
        end
        step(1'b1, vecs[2].k, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("stall_release_imm", imm, 32'h000A_BCDE);
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("stall_drain_q", exp_q.size(), 0);

        // Same-edge write and read of x7, then x0 write.
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd7, 32'h0000_1111);
        step(1'b1, 32'h0003_8081, 1'b1, 1'b1, 5'd7, 32'h0000_1234);
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_edge", rs1_data, 32'h0000_1234);
`else
        chk("wb_same_edge", rs1_data, 32'h0000_1111);
`endif
        step(1'b1, 32'h0003_8081, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("wb_after", rs1_data, 32'h0000_1234);
        step(1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_0081, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("x0_zero", rs1_data, 32'h0);

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, ($urandom & 32'hFFFF_FF80) | 32'h7F, 1'b1, 1'b0, 5'd0, 32'h0);
        end
        chk("err_sat", err_count, 8'hFF);
        step(1'b1, 32'h0000_007F, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("err_sat_hold", err_count, 8'hFF);

        // Reset while a bundle is stalled.
        step(1'b1, 32'h0000_007F, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("prestall_valid", out_valid, 1'b1);
        do_reset();

        // Randomized traffic.
        ops[0] = 7'h01; ops[1] = 7'h03; ops[2] = 7'h07; ops[3] = 7'h0F; ops[4] = 7'h00;
        for (int i = 0; i < 600; i++) begin
            k = $urandom;
            if ($urandom_range(0, 4) != 4) k = {k[31:7], ops[$urandom_range(0, 3)]};
            if ($urandom_range(0, 1) == 1) k[24:23] = 2'b00;
            if ($urandom_range(0, 1) == 1) k[19:18] = 2'b00;
            if ($urandom_range(0, 1) == 1) k[11:10] = 2'b00;
            wa = ($urandom_range(0, 2) == 0) ? k[19:15] : 5'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, k, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), wa, $urandom);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("final_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
